// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared FSM states, ROM base default and request tuple for the bus responder
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    HOLD,
    DONE
  } state_t;

  localparam logic [19:0] ROM_BASE_DEFAULT = 20'hF0000;

  // The core has no request strobe; this tuple is the request.
  typedef struct packed {
    logic [19:0] addr;
    logic        we;
    logic [7:0]  data;
  } req_t;

endpackage

// File: rtl/bus_sram_port.sv
// rtl/bus_sram_port.sv - registered SRAM pins, byte-lane select/replicate and read-byte capture
module bus_sram_port (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [19:0] addr,
  input  logic [7:0]  wdata,
  input  logic        start_rd,
  input  logic        start_wr,
  input  logic        stop,
  input  logic        capture,
  input  logic [15:0] sram_d_i,
  output logic [18:0] sram_a,
  output logic [15:0] sram_d_o,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic [7:0]  data_out
);

  logic lane_hi;

  // Address, data and lanes are loaded a cycle ahead of the strobe and held
  // until the next load, which gives the SRAM setup and hold around the strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      sram_a    <= '0;
      sram_d_o  <= '0;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
      lane_hi   <= 1'b0;
      data_out  <= '0;
    end else begin
      if (load) begin
        sram_a    <= addr[19:1];
        sram_d_o  <= {wdata, wdata};
        sram_ub_n <= ~addr[0];
        sram_lb_n <= addr[0];
        lane_hi   <= addr[0];
      end
      if (start_rd) sram_oe_n <= 1'b0;
      if (start_wr) sram_we_n <= 1'b0;
      if (stop) begin
        sram_oe_n <= 1'b1;
        sram_we_n <= 1'b1;
      end
      if (capture) data_out <= lane_hi ? sram_d_i[15:8] : sram_d_i[7:0];
    end
  end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - 8088 byte-bus responder to async 16-bit SRAM; BUS_ROM_PROTECT_EN blocks writes to the ROM region
module bus_responder
  import bus_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [19:0] ROM_BASE    = ROM_BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic        we,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        ready,
  output logic [18:0] sram_a,
  output logic [15:0] sram_d_o,
  input  logic [15:0] sram_d_i,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

`ifdef BUS_ROM_PROTECT_EN
  localparam logic ROM_PROTECT = 1'b1;
`else
  localparam logic ROM_PROTECT = 1'b0;
`endif

  state_t     state, state_nx;
  req_t       cur, req, tag;
  logic       tag_valid;
  logic       hit;
  logic [3:0] cnt;
  logic       wr_allowed;
  logic       load, start_rd, start_wr, stop, capture;

  assign cur        = {address, we, data_in};
  assign hit        = tag_valid && (tag == cur);
  assign ready      = (state == IDLE) && hit;
  assign wr_allowed = !(ROM_PROTECT && (req.addr >= ROM_BASE));

  // State, latched request, hold counter and served-request tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req       <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      if (load) req <= cur;
      if (state == STROBE) cnt <= 4'(WAIT_CYCLES - 1);
      else if (state == HOLD && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == DONE) begin
        tag       <= req;
        tag_valid <= 1'b1;
      end
    end
  end

  // Next state and SRAM port commands; a blocked ROM write still walks every state.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    start_rd = 1'b0;
    start_wr = 1'b0;
    stop     = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (!hit) begin
          load     = 1'b1;
          state_nx = STROBE;
        end
      end
      STROBE: begin
        start_rd = !req.we;
        start_wr = req.we && wr_allowed;
        state_nx = HOLD;
      end
      HOLD: begin
        if (cnt == 4'd0) state_nx = DONE;
      end
      DONE: begin
        stop     = 1'b1;
        capture  = !req.we;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  bus_sram_port u_port (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .addr      (cur.addr),
    .wdata     (cur.data),
    .start_rd  (start_rd),
    .start_wr  (start_wr),
    .stop      (stop),
    .capture   (capture),
    .sram_d_i  (sram_d_i),
    .sram_a    (sram_a),
    .sram_d_o  (sram_d_o),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n),
    .data_out  (data_out)
  );

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the 8088 core's byte bus: accepts the core's 20-bit address, write strobe and write data, and returns read data. It stalls the core through `ready`, which drives the core's `locked` enable, while it runs a multi-cycle access to an external asynchronous 16-bit SRAM. It sits between the core and board memory and replaces the ideal zero-wait memory model.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: SRAM access hold cycles (1..15) between strobe assertion and data capture.
- `ROM_BASE`, 20'hF0000: start of the write-protected BIOS region, which runs to 20'hFFFFF.

Ports:
- `clock`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  20  core byte address.
- `we`  in  1  core write strobe.
- `data_in`  in  8  core write data (core `out`).
- `data_out`  out  8  read data to the core (core `in`), registered.
- `ready`  out  1  to core `locked`. High means the current bus request is served. Combinational.
- `sram_a`  out  19  SRAM word address, equal to `address[19:1]`.
- `sram_d_o`  out  16  SRAM write data.
- `sram_d_i`  in  16  SRAM read data.
- `sram_oe_n`  out  1  output enable, active low.
- `sram_we_n`  out  1  write enable, active low.
- `sram_ub_n`  out  1  upper byte lane enable, active low.
- `sram_lb_n`  out  1  lower byte lane enable, active low.

## Operation
- The core has no request strobe. A request is the tuple {`address`, `we`, `data_in`}. The block keeps a tag of the last served tuple plus a `tag_valid` bit.
- `ready` = (state==IDLE) && `tag_valid` && (tag == current tuple). On any mismatch `ready` drops in the same cycle, which freezes the core so the tuple stays stable.
- FSM states:
  - IDLE: on mismatch, latch the tuple, drive `sram_a` and the lane enables, go to STROBE.
  - STROBE: assert `sram_oe_n`=0 for a read, or `sram_we_n`=0 for a write; load the counter with `WAIT_CYCLES`-1; go to HOLD.
  - HOLD: decrement the counter. At 0, go to DONE.
  - DONE: deassert both strobes. On a read, capture the lane byte into `data_out`. Write the tag, set `tag_valid`=1, return to IDLE.
- Byte lanes: `address[0]`=0 selects the lower lane (`sram_lb_n`=0); 1 selects the upper lane (`sram_ub_n`=0). Only one lane is enabled per access. On writes, `sram_d_o` = {`data_in`, `data_in`}.
- A write does not change `data_out`.
- Read-after-write to the same address differs in `we`, so it misses and performs a real read.
- Reset mid-access: all strobes deassert on the reset edge, the FSM goes to IDLE, `tag_valid` clears, and no SRAM write completes beyond that edge.

## Timing
- Reset values:
  - `data_out`=8'h00, `ready`=0 (tag invalid).
  - `sram_oe_n`=`sram_we_n`=`sram_ub_n`=`sram_lb_n`=1.
  - `sram_a`=0, `sram_d_o`=0.
- Miss latency: `ready` is low for exactly `WAIT_CYCLES`+3 cycles (IDLE miss, STROBE, HOLD×`WAIT_CYCLES`, DONE), then high in the following IDLE cycle with `data_out` valid.
- `sram_a`, `sram_d_o` and the lane enables are stable one cycle before the strobe asserts and one cycle after it deasserts. This gives address setup and hold for the SRAM.
- Back-to-back distinct requests: each pays the full miss latency. There is no pipelining.
- A tuple that is unchanged between cycles (core idle or repeated fetch) keeps `ready`=1 indefinitely.

## Configuration
- `BUS_ROM_PROTECT_EN` defined: a write with `address` >= `ROM_BASE` never asserts `sram_we_n`. The FSM still walks all states (same latency), and the tag is updated so the core proceeds.
- Undefined: the ROM region is ordinary writable SRAM.

## Structure
- Shared package `bus_pkg`: FSM state enum (IDLE, STROBE, HOLD, DONE), the default `ROM_BASE` constant, and the request-tuple struct {addr[19:0], we, data[7:0]}.
- One natural sub-module, `bus_sram_port`: registers the SRAM pins, performs the byte-lane select/replicate, and does the read-byte extraction. The FSM and tag logic stay in `bus_responder`.

## Test plan
- Reset, then read address 20'h00010 with SRAM word 16'hBEEF at `sram_a`=19'h00008 -> `ready` low for 5 cycles (`WAIT_CYCLES`=2), then `data_out`=8'hEF and `ready`=1.
- Read 20'h00011, same SRAM word -> `sram_ub_n`=0, `sram_lb_n`=1, `data_out`=8'hBE.
- Write 8'h5A to 20'h12345 -> `sram_a`=19'h091A2, `sram_d_o`=16'h5A5A, `sram_ub_n`=0, `sram_we_n` low for 3 cycles; `data_out` unchanged.
- Tuple held constant for 20 cycles after completion -> `ready` stays 1, no strobes asserted.
- With `BUS_ROM_PROTECT_EN`, write 8'h00 to 20'hFFFF0 -> `sram_we_n` stays 1, `ready` returns after 5 cycles.
- Assert `reset` during HOLD of a write -> on the next edge `sram_we_n`=1 and `ready`=0; the following read misses and completes normally.
